// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Requester ids are single-bit so they can double as a mux select.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-input round-robin picker: a lone requester always wins, and on a tie
// the requester that was not served last wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last_id,
  output logic id,
  output logic valid
);

  always_comb begin
    valid = req_a | req_b;
    id    = REQ_A;
    if (req_a && req_b) begin
      id = (last_id == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      id = REQ_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a latch-based byte memory between requesters A and B, running every
// access through a fixed setup -> strobe -> hold sequence.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  state_t            next_state;
  logic              cmd_id;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              last_id;
  logic              pick_id;
  logic              pick_valid;

  rr_pick2 u_pick (
    .req_a   (a_req),
    .req_b   (b_req),
    .last_id (last_id),
    .id      (pick_id),
    .valid   (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    a_gnt      = 1'b0;
    b_gnt      = 1'b0;
    a_done     = 1'b0;
    b_done     = 1'b0;
    case (state)
      IDLE:   if (pick_valid) next_state = SETUP;
      SETUP: begin
        next_state = STROBE;
        a_gnt      = (cmd_id == REQ_A);
        b_gnt      = (cmd_id == REQ_B);
      end
      STROBE: next_state = HOLD;
      HOLD: begin
        next_state = IDLE;
        a_done     = (cmd_id == REQ_A);
        b_done     = (cmd_id == REQ_B);
      end
      default: next_state = IDLE;
    endcase
  end

  // The command register only loads on acceptance, so the memory address and
  // data it feeds stay frozen for the whole setup/strobe/hold window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_id    <= REQ_A;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (state == IDLE && pick_valid) begin
      cmd_id    <= pick_id;
      cmd_we    <= (pick_id == REQ_B) ? b_we    : a_we;
      cmd_addr  <= (pick_id == REQ_B) ? b_addr  : a_addr;
      cmd_wdata <= (pick_id == REQ_B) ? b_wdata : a_wdata;
    end
  end

  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;

  // Enable comes straight from a flop so the latch gate never sees a decode glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_en <= 1'b0;
    end else begin
      mem_en <= (state == SETUP) && cmd_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_rdata <= '0;
      b_rdata <= '0;
      last_id <= REQ_B;
    end else begin
      if (state == STROBE && !cmd_we) begin
        if (cmd_id == REQ_A) a_rdata <= mem_rdata;
        else                 b_rdata <= mem_rdata;
      end
      if (state == HOLD) last_id <= cmd_id;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencing controller that shares the latch-based byte memory (4 × 8 by default, write-enable strobe, combinational read by address) between two requesters A and B. Accepts one request at a time with round-robin fairness, registers the command and drives the memory address, data and enable in a fixed setup → strobe → hold sequence. This guarantees that data and address are stable around every enable pulse. Sits between the switch/button front end or a future sequencer and the memory array.

## Interface
- DATA_W, 8, memory word width
- ADDR_W, 2, memory address width (2^ADDR_W words)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous, active-low reset
- a_req  in  1  requester A command request (level, sampled only in IDLE)
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  ADDR_W  A word address
- a_wdata  in  DATA_W  A write data
- a_gnt  out  1  one-cycle pulse: A's command accepted and registered
- a_done  out  1  one-cycle pulse: A's access complete
- a_rdata  out  DATA_W  A read data, valid while a_done is high after a read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: identical set for requester B
- mem_en  out  1  memory write enable (latch transparent while high)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr

## Operation
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE. No other transitions except reset to IDLE.
- IDLE:
  - If any req is high, pick a winner.
  - Register winner id, we, addr, wdata.
  - Go to SETUP.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req high → that requester wins.
  - Both high → the requester not served last wins.
  - Last-served pointer resets to B, so A wins the first tie.
- SETUP: mem_addr/mem_wdata driven from the registered command; mem_en=0; winner's gnt=1.
- STROBE: mem_en = registered we; address and data unchanged.
- HOLD:
  - mem_en=0; address and data unchanged.
  - Winner's done=1.
  - Winner's rdata register is loaded from mem_rdata at the STROBE→HOLD edge on reads, and left unchanged on writes.
  - Pointer updates to the winner.
- Requester obligations:
  - Hold req/we/addr/wdata stable until its gnt is seen.
  - Drop req in the cycle after gnt, or a new identical transaction is accepted at the next IDLE.
  - Inputs of a non-winning requester are ignored until it is granted.
- Reads never assert mem_en. Memory contents are never touched on a read.
- Non-granted requester's gnt/done are 0 throughout. At most one gnt and one done are high in any cycle.

## Timing
- Request seen in IDLE at edge N:
  - gnt high in cycle N+1 (SETUP).
  - mem_en high in cycle N+2 for writes.
  - done high in cycle N+3.
  - Back in IDLE in cycle N+4.
- Throughput: one access per 4 cycles. A request pending during a transaction is accepted at the first IDLE cycle.
- mem_addr and mem_wdata change only on the IDLE→SETUP edge. They are stable for ≥1 cycle before and after every mem_en pulse.
- Reset (rst_n=0 at an edge), any state:
  - State becomes IDLE.
  - mem_en, gnt, done, mem_addr, mem_wdata, a_rdata and b_rdata become 0.
  - Pointer returns to B.
- Reset during STROBE ends the enable at that edge. The addressed word keeps the value written while enable was high. No done is issued.

## Structure
- Shared package mem_arb_pkg:
  - state enum (IDLE, SETUP, STROBE, HOLD)
  - requester id constants REQ_A=0, REQ_B=1
  - default DATA_W/ADDR_W values
- One sub-module, rr_pick2: a two-input round-robin picker with pointer input, returning grant id and valid. It is purely combinational.
- FSM, command register and rdata registers live in mem_port_arbiter. The memory array itself is outside.

## Test plan
- Reset then idle:
  - Stimulus: rst_n=0 for 2 cycles, then release with no requests.
  - Response: all outputs 0; mem_en never rises in 10 cycles.
- Single write:
  - Stimulus: A writes 0x03 to addr 0.
  - Response: a_gnt at N+1; mem_en=1 only at N+2 with mem_addr=0 and mem_wdata=0x03; a_done at N+3.
  - Repeat for addr 1..3 with 0x0C/0x30/0xC0.
- Single read:
  - Stimulus: B reads addr 2 after the writes above.
  - Response: mem_en stays 0; b_done with b_rdata=0x30; a_rdata unchanged.
- Tie and fairness:
  - Stimulus: A and B both request after reset.
  - Response: A granted first, then B, then A (three back-to-back grants spaced 4 cycles apart).
- Held request:
  - Stimulus: A keeps a_req high for 12 cycles.
  - Response: exactly 3 grants; B requesting meanwhile is served in alternation.
- Reset mid-write:
  - Stimulus: rst_n=0 during STROBE of a write of 0xFF to addr 1.
  - Response: mem_en=0 next cycle, no a_done, FSM in IDLE; a subsequent read of addr 1 returns 0xFF.
